// File: rtl/serial_binary_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_binary_adder_pkg;

    // Default operand/sum width in bits (must be >= 2).
    localparam int SBA_N_DEFAULT = 8;

    // Controller states; the encodings are fixed so other blocks and debug views agree.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed-overflow rule for the most significant bit: operands of equal sign
    // producing a sum bit of the opposite sign.
    function automatic logic msb_overflow(input logic a, input logic b, input logic s);
        return (a == b) && (s != a);
    endfunction

endpackage

// File: rtl/serial_binary_adder_if.sv
// Request/result bundle of the bit-serial adder.
// master: the requester driving operands; slave: the adder itself.
interface serial_binary_adder_if
    import serial_binary_adder_pkg::*;
#(
    parameter int N = SBA_N_DEFAULT
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cIn;
    logic         ready;
    logic         done;
    logic [N-1:0] z;
    logic         c;
    logic         v;

    modport master (
        output start, x, y, cIn,
        input  ready, done, z, c, v
    );

    modport slave (
        input  start, x, y, cIn,
        output ready, done, z, c, v
    );
endinterface

// File: rtl/serial_binary_adder_full_adder.sv
// Single-bit full adder built from gate primitives; one instance serves every bit slot.
module full_adder (
    output wire s,
    output wire co,
    input  wire a,
    input  wire b,
    input  wire ci
);
    wire w_axb;
    wire w_ab;
    wire w_cx;

    xor g_x0 (w_axb, a, b);
    xor g_x1 (s, w_axb, ci);
    and g_a0 (w_ab, a, b);
    and g_a1 (w_cx, w_axb, ci);
    or  g_o0 (co, w_ab, w_cx);
endmodule

// File: rtl/serial_binary_adder.sv
// Bit-serial N-bit two's-complement adder: one full adder, LSB first, N clocks per add.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | waiting for start; ready=1; previous z/c/v held
//  ST_RUN  | one sum bit per clock shifted into z from the top
//  ST_DONE | one-cycle done strobe; z/c/v valid, then back to IDLE
module serial_binary_adder
    import serial_binary_adder_pkg::*;
#(
    parameter int N = SBA_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_binary_adder_if.slave bus
);
    localparam int             CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_xs;
    logic [N-1:0]  r_ys;
    logic [N-1:0]  r_z;
    logic          r_carry;
    logic          r_c;
    logic          r_v;
    logic          r_done;

    logic          w_s;
    logic          w_co;
    logic          w_last;
    logic          w_accept;

    // The only arithmetic in the block: current LSBs plus the running carry.
    full_adder u_fa (
        .s  (w_s),
        .co (w_co),
        .a  (r_xs[0]),
        .b  (r_ys[0]),
        .ci (r_carry)
    );

    assign w_last   = (r_count == LAST);
    assign w_accept = bus.start && (r_state == ST_IDLE);

    // Controller, operand/result shift registers and result flags in one state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_xs    <= '0;
            r_ys    <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_xs    <= bus.x;
                        r_ys    <= bus.y;
                        r_carry <= bus.cIn;
                        r_count <= '0;
                        r_z     <= '0;
                        r_c     <= 1'b0;
                        r_v     <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_z     <= {w_s, r_z[N-1:1]};
                    r_xs    <= {1'b0, r_xs[N-1:1]};
                    r_ys    <= {1'b0, r_ys[N-1:1]};
                    r_carry <= w_co;
                    if (w_last) begin
                        // Bit N-1 is in the adder now: capture carry-out and sign overflow.
                        // The counter holds at N-1 rather than wrapping.
                        r_c     <= w_co;
                        r_v     <= msb_overflow(r_xs[0], r_ys[0], w_s);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.done  = r_done;
    assign bus.z     = r_z;
    assign bus.c     = r_c;
    assign bus.v     = r_v;

endmodule

// File: tb/tb_serial_binary_adder.sv
// Directed bench for the bit-serial adder: vector table plus start-ignore and reset sequences.
module tb_serial_binary_adder;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         cin;
        logic [N-1:0] ez;
        logic         ec;
        logic         ev;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_binary_adder_if #(.N(N)) bus ();

    serial_binary_adder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after an edge with the DUT idle. Returns #1 after edge A+N+1.
    // Optionally pulses start with other operands after edge A+3.
    task automatic run_op(input vec_t t, input bit inject, input string tag);
        bus.start = 1'b1;
        bus.x     = t.x;
        bus.y     = t.y;
        bus.cIn   = t.cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x     = ~t.x;
        bus.y     = 8'h5A;
        bus.cIn   = ~t.cin;
        for (int k = 1; k <= N; k++) begin
            chk({tag, " ready low"}, {31'd0, bus.ready}, 32'd0);
            chk({tag, " done timing"}, {31'd0, bus.done}, 32'd0);
            if (inject && k == 3) begin
                bus.start = 1'b1;
                bus.x     = 8'hFF;
                bus.y     = 8'hFF;
                bus.cIn   = 1'b1;
            end
            if (inject && k == 4) bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        // Cycle following edge A+N: the done cycle.
        chk({tag, " done high"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " ready in done"}, {31'd0, bus.ready}, 32'd0);
        chk({tag, " z"}, {24'd0, bus.z}, {24'd0, t.ez});
        chk({tag, " c"}, {31'd0, bus.c}, {31'd0, t.ec});
        chk({tag, " v"}, {31'd0, bus.v}, {31'd0, t.ev});
        @(posedge clk);
        #1;
        chk({tag, " done one wide"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " ready back"}, {31'd0, bus.ready}, 32'd1);
        chk({tag, " z held"}, {24'd0, bus.z}, {24'd0, t.ez});
        chk({tag, " c held"}, {31'd0, bus.c}, {31'd0, t.ec});
        chk({tag, " v held"}, {31'd0, bus.v}, {31'd0, t.ev});
    endtask

    vec_t vecs[8];
    vec_t tv;

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{x: 8'h05, y: 8'h03, cin: 1'b0, ez: 8'h08, ec: 1'b0, ev: 1'b0};
        vecs[1] = '{x: 8'h7F, y: 8'h01, cin: 1'b0, ez: 8'h80, ec: 1'b0, ev: 1'b1};
        vecs[2] = '{x: 8'hFF, y: 8'h01, cin: 1'b0, ez: 8'h00, ec: 1'b1, ev: 1'b0};
        vecs[3] = '{x: 8'h80, y: 8'h80, cin: 1'b0, ez: 8'h00, ec: 1'b1, ev: 1'b1};
        vecs[4] = '{x: 8'hFF, y: 8'h00, cin: 1'b1, ez: 8'h00, ec: 1'b1, ev: 1'b0};
        vecs[5] = '{x: 8'h3C, y: 8'h55, cin: 1'b0, ez: 8'h91, ec: 1'b0, ev: 1'b1};
        vecs[6] = '{x: 8'h90, y: 8'hA0, cin: 1'b0, ez: 8'h30, ec: 1'b1, ev: 1'b1};
        vecs[7] = '{x: 8'hAA, y: 8'h55, cin: 1'b1, ez: 8'h00, ec: 1'b1, ev: 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.cIn   = 1'b0;
        #1;
        chk("reset ready", {31'd0, bus.ready}, 32'd1);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset z", {24'd0, bus.z}, 32'd0);
        chk("reset c", {31'd0, bus.c}, 32'd0);
        chk("reset v", {31'd0, bus.v}, 32'd0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back operations: each starts at the earliest edge A+N+2.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Start pulsed during RUN must be ignored.
        run_op(vecs[0], 1'b1, "ignore");
        for (int k = 0; k < 3; k++) begin
            chk("ignore no restart", {31'd0, bus.ready}, 32'd1);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-operation, between edges A+4 and A+5.
        tv = '{x: 8'h12, y: 8'h34, cin: 1'b0, ez: 8'h46, ec: 1'b0, ev: 1'b0};
        bus.start = 1'b1;
        bus.x     = tv.x;
        bus.y     = tv.y;
        bus.cIn   = tv.cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset z partial", {24'd0, bus.z}, 32'h60);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst z", {24'd0, bus.z}, 32'd0);
        chk("midrst c", {31'd0, bus.c}, 32'd0);
        chk("midrst v", {31'd0, bus.v}, 32'd0);
        chk("midrst ready", {31'd0, bus.ready}, 32'd1);
        chk("midrst done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk);
            #1;
            chk("post-reset no done", {31'd0, bus.done}, 32'd0);
        end

        tv = '{x: 8'h10, y: 8'h22, cin: 1'b0, ez: 8'h32, ec: 1'b0, ev: 1'b0};
        run_op(tv, 1'b0, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
